// File: rtl/pipes.sv
// Shared definitions for the execute-stage M-extension unit.
//   muldiv_op_t    : decoded RV64M operation code (4 bits)
//   muldiv_state_t : muldiv_unit control states
//   helpers        : op classification predicates and word sign-extension
package pipes;

    typedef enum logic [3:0] {
        MD_MUL   = 4'd0,
        MD_MULW  = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_REM   = 4'd4,
        MD_REMU  = 4'd5,
        MD_DIVW  = 4'd6,
        MD_DIVUW = 4'd7,
        MD_REMW  = 4'd8,
        MD_REMUW = 4'd9
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

    // Ops that work on the low 32 bits and sign-extend a 32-bit result.
    function automatic logic is_word_op(muldiv_op_t op);
        case (op)
            MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // Ops whose operands are interpreted as two's complement.
    function automatic logic is_signed_op(muldiv_op_t op);
        case (op)
            MD_DIV, MD_REM, MD_DIVW, MD_REMW: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul_op(muldiv_op_t op);
        return (op == MD_MUL) || (op == MD_MULW);
    endfunction

    function automatic logic is_rem_op(muldiv_op_t op);
        case (op)
            MD_REM, MD_REMU, MD_REMW, MD_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] sext_word(logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_restoring.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start_i      : load operands and begin (64 or 32 iterations per word_i)
//   word_i       : 32-bit operation; operands must be zero-extended magnitudes
//   dividend_i   : dividend magnitude
//   divisor_i    : divisor magnitude (non-zero; zero is handled by the caller)
//   quotient_o   : quotient (low 32 bits valid for word ops)
//   remainder_o  : remainder
//   finish_o     : high during the cycle that performs the last iteration
module div_restoring (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        word_i,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    output logic [63:0] quotient_o,
    output logic [63:0] remainder_o,
    output logic        finish_o
);

    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dvs_q;
    logic [6:0]  cnt_q;

    logic [64:0] shifted;
    logic [64:0] diff;
    logic        fits;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    always_comb begin
        shifted = {rem_q, quo_q[63]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = !diff[64];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            // Word ops park the dividend in the upper half so its MSB shifts out first.
            quo_q <= word_i ? {dividend_i[31:0], 32'h0} : dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= word_i ? 7'd32 : 7'd64;
        end else if (cnt_q != 7'd0) begin
            rem_q <= fits ? diff[63:0] : shifted[63:0];
            quo_q <= {quo_q[62:0], fits};
            cnt_q <= cnt_q - 7'd1;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign finish_o    = (cnt_q == 7'd1);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit sitting beside the ALU in execute.
//   clk, reset : clock, synchronous active-high reset
//   valid      : execute stage holds an M-extension instruction
//   op         : muldiv_op_t operation code
//   a, b       : rs1 / rs2 operands
//   hold       : downstream frozen; result must stay presented
//   flush      : abort and return to IDLE
//   exe_wait   : stall request to the hazard unit (combinational)
//   done       : result valid this cycle
//   result     : operation result, zero outside DONE
module muldiv_unit
    import pipes::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hold,
    input  logic            flush,
    output logic            exe_wait,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;

    muldiv_op_t    op_q;
    logic [63:0]   a_q;
    logic          dz_q, ovf_q, q_neg_q, r_neg_q;
    logic [63:0]   acc_q, mcand_q, mplier_q;

    // Decode of the incoming instruction.
    muldiv_op_t  op_in;
    logic        in_word, in_signed, in_mul;
    logic        a_sgn, b_sgn;
    logic [63:0] a_ext, b_ext, a_neg, b_neg, a_mag, b_mag;
    logic        dz_in, ovf_in, special_in;
    logic        start, div_start, last_iter;

    logic [63:0] div_quo, div_rem;
    logic        div_finish;
    logic [63:0] res_fix;

    always_comb begin
        op_in     = muldiv_op_t'(op);
        in_word   = is_word_op(op_in);
        in_signed = is_signed_op(op_in);
        in_mul    = is_mul_op(op_in);
        a_ext     = in_word ? {32'h0, a[31:0]} : a;
        b_ext     = in_word ? {32'h0, b[31:0]} : b;
        a_sgn     = in_signed && (in_word ? a[31] : a[63]);
        b_sgn     = in_signed && (in_word ? b[31] : b[63]);
        a_neg     = -a_ext;
        b_neg     = -b_ext;
        a_mag     = a_sgn ? (in_word ? {32'h0, a_neg[31:0]} : a_neg) : a_ext;
        b_mag     = b_sgn ? (in_word ? {32'h0, b_neg[31:0]} : b_neg) : b_ext;
        dz_in     = !in_mul && (b_ext == 64'h0);
        ovf_in    = !in_mul && in_signed &&
                    (in_word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                             : ((a == 64'h8000_0000_0000_0000) && (b == '1)));
        special_in = dz_in || ovf_in;
        start      = (state_q == IDLE) && valid && !flush;
        div_start  = start && !in_mul && !special_in;
    end

    // Mul and div counters run in lockstep; the divider flags its own last step.
    assign last_iter = is_mul_op(op_q) ? (cnt_q == 7'd1) : div_finish;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        if (special_in) begin
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = in_word ? 7'd32 : 7'd64;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - 7'd1;
                    if (last_iter) state_d = DONE;
                end
                DONE: begin
                    // valid may still be high here; only IDLE accepts a new op.
                    if (!hold) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand latch and shift-add multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MD_MUL;
            a_q      <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            op_q     <= op_in;
            a_q      <= a;
            dz_q     <= dz_in;
            ovf_q    <= ovf_in;
            q_neg_q  <= a_sgn ^ b_sgn;
            r_neg_q  <= a_sgn;
            acc_q    <= '0;
            // Low product bits are sign-agnostic, so raw operands suffice.
            mcand_q  <= a_ext;
            mplier_q <= b_ext;
        end else if ((state_q == BUSY) && is_mul_op(op_q)) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 64'h0);
            mcand_q  <= {mcand_q[62:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[63:1]};
        end
    end

    div_restoring u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .word_i     (in_word),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .finish_o   (div_finish)
    );

    function automatic logic [63:0] sign_fix(logic [63:0] v, logic neg, logic word);
        logic [63:0] t;
        t = neg ? -v : v;
        return word ? sext_word(t[31:0]) : t;
    endfunction

    // Final result from registered state; only presented in DONE.
    always_comb begin
        res_fix = '0;
        if (is_mul_op(op_q)) begin
            res_fix = is_word_op(op_q) ? sext_word(acc_q[31:0]) : acc_q;
        end else if (dz_q) begin
            res_fix = is_rem_op(op_q) ? (is_word_op(op_q) ? sext_word(a_q[31:0]) : a_q) : '1;
        end else if (ovf_q) begin
            res_fix = is_rem_op(op_q) ? 64'h0
                                      : (is_word_op(op_q) ? sext_word(a_q[31:0]) : a_q);
        end else if (is_rem_op(op_q)) begin
            res_fix = sign_fix(div_rem, r_neg_q, is_word_op(op_q));
        end else begin
            res_fix = sign_fix(div_quo, q_neg_q, is_word_op(op_q));
        end
    end

    // Outputs.
    always_comb begin
        exe_wait = !flush && (((state_q == IDLE) && valid) || (state_q == BUSY));
        done     = (state_q == DONE);
        result   = done ? res_fix : '0;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        exe_wait;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .op      (op),
        .a       (a),
        .b       (b),
        .hold    (hold),
        .flush   (flush),
        .exe_wait(exe_wait),
        .done    (done),
        .result  (result)
    );

    // Presents an op and counts exe_wait cycles; returns in DONE with valid still high.
    task automatic issue_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                            output int waits, output logic dn, output logic [63:0] res);
        @(posedge clk); #1;
        valid = 1'b1; op = o; a = x; b = y;
        waits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!exe_wait) break;
            waits++;
        end
        if (exe_wait) waits = -1;
        dn  = done;
        res = result;
    endtask

    task automatic retire();
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL reset_wait_idle got %0b want 0", exe_wait); end
        valid = 1'b1; #1;
        checks++; if (exe_wait !== 1'b1) begin errors++; $display("FAIL reset_wait_valid got %0b want 1", exe_wait); end
        flush = 1'b1; #1;
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL reset_wait_flush got %0b want 0", exe_wait); end
        valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int w; logic dn; logic [63:0] r;
        issue_op(MD_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, w, dn, r);
        checks++; if (w !== 65) begin errors++; $display("FAIL mul_wait got %0d want 65", w); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mul_done got %0b want 1", dn); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mul_neg got %h want fffffffffffffff1", r); end
        retire();
        issue_op(MD_MUL, 64'h1_0000_0001, 64'h1_0000_0001, w, dn, r);
        checks++; if (r !== 64'h0000_0002_0000_0001) begin errors++; $display("FAIL mul_wrap got %h want 0000000200000001", r); end
        retire();
    endtask

    task automatic test_div();
        int w; logic dn; logic [63:0] r;
        issue_op(MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, w, dn, r);
        checks++; if (w !== 65) begin errors++; $display("FAIL div_wait got %0d want 65", w); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffffffffffd", r); end
        retire();
        issue_op(MD_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, w, dn, r);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffffffffffff", r); end
        retire();
    endtask

    task automatic test_special();
        int w; logic dn; logic [63:0] r;
        issue_op(MD_DIVU, 64'd5, 64'd0, w, dn, r);
        checks++; if (w !== 1) begin errors++; $display("FAIL divu0_wait got %0d want 1", w); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu0 got %h want ffffffffffffffff", r); end
        retire();
        issue_op(MD_REMU, 64'd5, 64'd0, w, dn, r);
        checks++; if (r !== 64'd5) begin errors++; $display("FAIL remu0 got %h want 5", r); end
        retire();
        issue_op(MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, w, dn, r);
        checks++; if (w !== 1) begin errors++; $display("FAIL divovf_wait got %0d want 1", w); end
        checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL divovf got %h want 8000000000000000", r); end
        retire();
        issue_op(MD_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, w, dn, r);
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL removf got %h want 0", r); end
        retire();
    endtask

    task automatic test_word();
        int w; logic dn; logic [63:0] r;
        issue_op(MD_MULW, 64'h7FFF_FFFF, 64'd2, w, dn, r);
        checks++; if (w !== 33) begin errors++; $display("FAIL mulw_wait got %0d want 33", w); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulw got %h want fffffffffffffffe", r); end
        retire();
        issue_op(MD_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, w, dn, r);
        checks++; if (w !== 1) begin errors++; $display("FAIL divwovf_wait got %0d want 1", w); end
        checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL divwovf got %h want ffffffff80000000", r); end
        retire();
        issue_op(MD_DIVUW, 64'hABCD_0000_FFFF_FFFE, 64'h1234_0000_0000_0001, w, dn, r);
        checks++; if (w !== 33) begin errors++; $display("FAIL divuw_wait got %0d want 33", w); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL divuw_sext got %h want fffffffffffffffe", r); end
        retire();
        issue_op(MD_REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, w, dn, r);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL remw_neg got %h want ffffffffffffffff", r); end
        retire();
    endtask

    task automatic test_hold();
        int w; logic dn; logic [63:0] r;
        hold = 1'b1;
        issue_op(MD_MUL, 64'd6, 64'd7, w, dn, r);
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL hold_first got %h want 2a", r); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got %0b want 1", done); end
            checks++; if (result !== 64'd42) begin errors++; $display("FAIL hold_result got %h want 2a", result); end
            checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL hold_wait got %0b want 0", exe_wait); end
        end
        @(posedge clk); #1;
        hold = 1'b0;
        issue_op(MD_DIVU, 64'd100, 64'd7, w, dn, r);
        checks++; if (w !== 65) begin errors++; $display("FAIL after_hold_wait got %0d want 65", w); end
        checks++; if (r !== 64'd14) begin errors++; $display("FAIL after_hold_divu got %h want e", r); end
    endtask

    task automatic test_back_to_back();
        int w; logic dn; logic [63:0] r;
        issue_op(MD_REMU, 64'd100, 64'd7, w, dn, r);
        checks++; if (w !== 65) begin errors++; $display("FAIL b2b_wait got %0d want 65", w); end
        checks++; if (r !== 64'd2) begin errors++; $display("FAIL b2b_remu got %h want 2", r); end
        retire();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done got %0b want 0", done); end
    endtask

    task automatic test_flush();
        int seen;
        @(posedge clk); #1;
        valid = 1'b1; op = MD_DIVU; a = 64'd1000; b = 64'd3;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (exe_wait !== 1'b1) begin errors++; $display("FAIL flush_busy got %0b want 1", exe_wait); end
        flush = 1'b1; #1;
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL flush_wait got %0b want 0", exe_wait); end
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL flush_idle got %0b want 0", exe_wait); end
        seen = 0;
        repeat (80) begin @(negedge clk); if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", seen); end
        // flush alongside valid in IDLE must not start anything
        @(posedge clk); #1;
        valid = 1'b1; flush = 1'b1; op = MD_MUL; a = 64'd6; b = 64'd7;
        #1;
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL flush_idle_wait got %0b want 0", exe_wait); end
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL flush_no_start got %0b want 0", exe_wait); end
    endtask

    task automatic test_reset_busy();
        int seen; int w; logic dn; logic [63:0] r;
        @(posedge clk); #1;
        valid = 1'b1; op = MD_DIV; a = 64'd99; b = 64'd4;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstbusy_done got %0b want 0", done); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL rstbusy_result got %h want 0", result); end
        checks++; if (exe_wait !== 1'b0) begin errors++; $display("FAIL rstbusy_wait got %0b want 0", exe_wait); end
        seen = 0;
        repeat (80) begin @(negedge clk); if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstbusy_no_done got %0d want 0", seen); end
        issue_op(MD_MUL, 64'd6, 64'd7, w, dn, r);
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL rstbusy_recover got %h want 2a", r); end
        retire();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, beside the ALU.
- It consumes the decoded M-extension op and its operands from the D/E pipeline register.
- It drives exe_wait into the hazard unit, which holds PC/F/D and flushes the E/M register while the unit computes.
- It stays in step with the pipeline through hold (pipeline frozen downstream) and flush.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid  in  1  execute stage holds an M-extension instruction
op  in  4  muldiv_op_t operation code
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
hold  in  1  downstream frozen this cycle (dmem_wait); result must not be consumed
flush  in  1  abort the current operation and return to IDLE
exe_wait  out  1  stall request to the hazard unit
done  out  1  result valid this cycle
result  out  XLEN  operation result

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, counter=0, internal registers=0. Outputs after reset: done=0, result=0, exe_wait=valid&&!flush.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - valid&&!flush: latch op/a/b.
  - Special case (divide by zero, or signed overflow) → DONE next cycle.
  - Otherwise → BUSY with counter=N, where N=64 for 64-bit ops and N=32 for W ops.
- BUSY: one iteration per cycle, counter decrements; counter reaching 1 → DONE.
- DONE:
  - done=1; result held stable.
  - !hold → IDLE.
  - hold → stay in DONE.
  - A still-asserted valid in DONE does not restart the unit.
- exe_wait = !flush && ((IDLE&&valid) || BUSY). It is combinational so the stall asserts in the same cycle the instruction enters execute.
- Latency: exe_wait is high for exactly 1+N cycles (65 for 64-bit ops, 33 for W ops), then done=1 with exe_wait=0. Special cases: exe_wait is high 1 cycle.
- Multiply: radix-2 shift-add; the low XLEN bits of the product are kept.
  - MUL: 64-bit product low bits.
  - MULW: product of a[31:0]*b[31:0], low 32 bits, sign-extended to 64.
- Divide: restoring divide on magnitudes.
  - Signed ops negate operands first and fix signs at the end: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
  - W ops use the low 32 bits, signed ops sign-interpret bit 31, and the 32-bit result is sign-extended to 64 for all W ops, including DIVUW/REMUW.
- Division special cases, evaluated on the latched W-truncated operands:
  - Divisor zero: quotient = all ones (width-appropriate, then sign-extended); remainder = dividend.
  - Signed overflow (most-negative ÷ -1): quotient = dividend; remainder = 0.
- flush: highest priority after reset; from any state → IDLE next cycle. If asserted with valid in IDLE, no operation starts.
- reset mid-BUSY: → IDLE, and the result is discarded.
- Back-to-back ops: the unit leaves DONE with !hold, and the next instruction's valid in IDLE starts a new operation on the following cycle. There are no idle bubbles beyond that.

Decomposition:
- Package pipes gets:
  - muldiv_op_t enum: MD_MUL, MD_MULW, MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW.
  - muldiv_state_t enum: IDLE, BUSY, DONE.
- Package pipes gets helper predicates is_word_op and is_signed_op.
- One sub-module: div_restoring, the iterative magnitude divider (start, dividend, divisor, width select → quotient, remainder, finish).
- The shift-add multiplier, sign fix-up and FSM stay in muldiv_unit.

Test Plan:
1. MUL a=3, b=0xFFFF_FFFF_FFFF_FFFB → exe_wait high 65 cycles; then done=1, result=0xFFFF_FFFF_FFFF_FFF1.
2. DIV a=-7, b=2 → result=0xFFFF_FFFF_FFFF_FFFD after 65 cycles. REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
3. DIVU a=5, b=0 → exe_wait 1 cycle, result=0xFFFF_FFFF_FFFF_FFFF. REMU a=5, b=0 → 5. DIV a=0x8000_0000_0000_0000, b=-1 → result=0x8000_0000_0000_0000. REM with the same operands → 0.
4. MULW a=0x7FFF_FFFF, b=2 → exe_wait 33 cycles, result=0xFFFF_FFFF_FFFF_FFFE. DIVW a=0x8000_0000, b=0xFFFF_FFFF → result=0xFFFF_FFFF_8000_0000.
5. hold=1 for 3 cycles on entering DONE → done and result stable, exe_wait=0 throughout. Then hold=0 → IDLE, and a new DIVU 100/7 → 14 after 65 cycles.
6. flush at BUSY iteration 10 → exe_wait=0 that cycle, IDLE next cycle, done never asserts. reset mid-BUSY gives the same result with result=0.
